// File: rtl/axi_single_beat_master_pkg.sv
// Shared AXI constants and the master FSM state type.
package axi_single_beat_master_pkg;

    localparam int unsigned ID_W    = 4;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RESP_W  = 2;

    localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;
    localparam logic [SIZE_W-1:0]  SIZE_WORD  = 3'b010;
    localparam logic [LEN_W-1:0]   LEN_SINGLE = 4'd0;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_e;

endpackage

// File: rtl/axi_single_beat_master.sv
// Single-beat AXI4 initiator: one core request becomes one AR/R or AW/W/B transaction.
module axi_single_beat_master
    import axi_single_beat_master_pkg::*;
#(
    parameter logic [ID_W-1:0] ID_VAL = 4'd0,
    parameter int unsigned     ADDR_W = 32,
    parameter int unsigned     DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // core side
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  err_o,
    // AR channel
    output logic [ID_W-1:0]       arid_o,
    output logic [ADDR_W-1:0]     araddr_o,
    output logic [LEN_W-1:0]      arlen_o,
    output logic [SIZE_W-1:0]     arsize_o,
    output logic [BURST_W-1:0]    arburst_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    // R channel
    input  logic [ID_W-1:0]       rid_i,
    input  logic [DATA_W-1:0]     rdata_i,
    input  logic [RESP_W-1:0]     rresp_i,
    input  logic                  rlast_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    // AW channel
    output logic [ID_W-1:0]       awid_o,
    output logic [ADDR_W-1:0]     awaddr_o,
    output logic [LEN_W-1:0]      awlen_o,
    output logic [SIZE_W-1:0]     awsize_o,
    output logic [BURST_W-1:0]    awburst_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    // W channel
    output logic [DATA_W-1:0]     wdata_o,
    output logic [DATA_W/8-1:0]   wstrb_o,
    output logic                  wlast_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    // B channel
    input  logic [ID_W-1:0]       bid_i,
    input  logic [RESP_W-1:0]     bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                aw_ok_q, aw_ok_d;
    logic                w_ok_q, w_ok_d;

    logic                aw_hs, w_hs;

    assign aw_hs = awvalid_q & awready_i;
    assign w_hs  = wvalid_q & wready_i;

    // State and registered outputs; reset drops every VALID/READY at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_ok_q   <= 1'b0;
            w_ok_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            done_q    <= done_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_ok_q   <= aw_ok_d;
            w_ok_q    <= w_ok_d;
        end
    end

    // Next-state and next-output logic for the transaction sequence.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        done_d    = 1'b0;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_ok_d   = aw_ok_q;
        w_ok_d    = w_ok_q;

        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    wstrb_d = wstrb_i;
                    aw_ok_d = 1'b0;
                    w_ok_d  = 1'b0;
                    if (we_i) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid_i && rready_q) begin
                    rdata_d  = rdata_i;
                    err_d    = (rresp_i != RESP_OKAY) | ~rlast_i | (rid_i != ID_VAL);
                    rready_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            WR_REQ: begin
                aw_ok_d = aw_ok_q | aw_hs;
                w_ok_d  = w_ok_q | w_hs;
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if (aw_ok_d && w_ok_d) begin
                    bready_d = 1'b1;
                    aw_ok_d  = 1'b0;
                    w_ok_d   = 1'b0;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid_i && bready_q) begin
                    err_d    = (bresp_i != RESP_OKAY) | (bid_i != ID_VAL);
                    bready_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;

    assign arid_o    = ID_VAL;
    assign araddr_o  = addr_q;
    assign arlen_o   = LEN_SINGLE;
    assign arsize_o  = SIZE_WORD;
    assign arburst_o = BURST_INCR;
    assign arvalid_o = arvalid_q;
    assign rready_o  = rready_q;

    assign awid_o    = ID_VAL;
    assign awaddr_o  = addr_q;
    assign awlen_o   = LEN_SINGLE;
    assign awsize_o  = SIZE_WORD;
    assign awburst_o = BURST_INCR;
    assign awvalid_o = awvalid_q;

    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;
    assign wlast_o   = wvalid_q;
    assign wvalid_o  = wvalid_q;
    assign bready_o  = bready_q;

endmodule
